// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged synchronous FIFO: pointer/count width
// helper and parameter legality predicates used at elaboration time.
package fifo_pkg;

    // Pointer and occupancy width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

    // DEPTH must be a power of two and at least 2.
    function automatic bit depth_ok(input int depth);
        return (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
    endfunction

    // almost_full threshold must lie in 1..DEPTH.
    function automatic bit af_level_ok(input int depth, input int af_level);
        return (af_level >= 32'sd1) && (af_level <= depth);
    endfunction

    // almost_empty threshold must lie in 0..DEPTH-1.
    function automatic bit ae_level_ok(input int depth, input int ae_level);
        return (ae_level >= 32'sd0) && (ae_level <= (depth - 32'sd1));
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage for sync_fifo_flagged: synchronous write port,
// asynchronous read port. Contents are not reset; the FIFO pointers define
// which entries are valid.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Store the incoming word on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and one-cycle overflow / underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise
// data_out is a register loaded on each accepted read.
module sync_fifo_flagged
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_en,
    input  logic                      r_en,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);
    localparam logic [PW-1:0] ONE_C   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};

    // Reject illegal configurations at elaboration.
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_flagged: DEPTH must be a power of two >= 2");
    end
    if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
        $error("sync_fifo_flagged: AF_LEVEL out of range 1..DEPTH");
    end
    if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
        $error("sync_fifo_flagged: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             full_s;
    logic             empty_s;
    logic             almost_full_s;
    logic             almost_empty_s;
    logic [WIDTH-1:0] mem_rd_data_s;

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr_r[AW-1:0]),
        .rd_data (mem_rd_data_s)
    );

    // Status flags decode only from the registered occupancy.
    always_comb begin
        full_s         = (count_r == DEPTH_C);
        empty_s        = (count_r == ZERO_C);
        almost_full_s  = (count_r >= AF_C);
        almost_empty_s = (count_r <= AE_C);
    end

    // Acceptance is judged on pre-edge state, so no pass-through on full/empty.
    always_comb begin
        wr_acc_s = w_en && !full_s;
        rd_acc_s = r_en && !empty_s;
    end

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            count_r     <= ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
            overflow_r  <= w_en && full_s;
            underflow_r <= r_en && empty_s;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    logic [WIDTH-1:0] data_out_s;

    // Head word falls through whenever the FIFO holds data.
    always_comb begin
        if (empty_s) begin
            data_out_s = {WIDTH{1'b0}};
        end else begin
            data_out_s = mem_rd_data_s;
        end
    end

    assign data_out = data_out_s;
`else
    logic [WIDTH-1:0] data_out_r;

    // Output register loads the head word on an accepted read and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= {WIDTH{1'b0}};
        end else if (rd_acc_s) begin
            data_out_r <= mem_rd_data_s;
        end
    end

    assign data_out = data_out_r;
`endif

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = almost_full_s;
    assign almost_empty = almost_empty_s;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule
